// File: rtl/elementwise_divider_if.sv
// Handshake and vector bus between a producer, the element-wise divider and its consumer.
// Operands flow in on n*/d*, and results come back on q*/r*/dz.
interface elementwise_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] n1, n2, n3, n4;
    logic [WIDTH-1:0] d1, d2, d3, d4;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q1, q2, q3, q4;
    logic [WIDTH-1:0] r1, r2, r3, r4;
    logic [3:0]       dz;

    modport master (
        output in_valid, n1, n2, n3, n4, d1, d2, d3, d4, out_ready,
        input  in_ready, out_valid, q1, q2, q3, q4, r1, r2, r3, r4, dz
    );

    modport slave (
        input  in_valid, n1, n2, n3, n4, d1, d2, d3, d4, out_ready,
        output in_ready, out_valid, q1, q2, q3, q4, r1, r2, r3, r4, dz
    );
endinterface

// File: rtl/elementwise_divider.sv
// Four-lane unsigned divider: one shared restoring-division step per clock, lanes processed
// in order, so every operation takes exactly 4*WIDTH DIV cycles regardless of the data.
module elementwise_divider #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    elementwise_divider_if.slave   bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state_reg;
    logic             out_valid_reg;
    logic [1:0]       lane_reg;
    logic [BW-1:0]    bit_reg;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-2:0] qacc_reg;
    logic [3:0]       dz_reg;
    logic [WIDTH-1:0] n_reg [4];
    logic [WIDTH-1:0] d_reg [4];
    logic [WIDTH-1:0] q_reg [4];
    logic [WIDTH-1:0] r_reg [4];

    logic [WIDTH-1:0] n_in [4];
    logic [WIDTH-1:0] d_in [4];

    assign n_in[0] = bus.n1;
    assign n_in[1] = bus.n2;
    assign n_in[2] = bus.n3;
    assign n_in[3] = bus.n4;
    assign d_in[0] = bus.d1;
    assign d_in[1] = bus.d2;
    assign d_in[2] = bus.d3;
    assign d_in[3] = bus.d4;

    // Shared datapath: shift in the next dividend bit, trial-subtract the divisor.
    logic [WIDTH-1:0] n_lane;
    logic [WIDTH-1:0] d_lane;
    logic [WIDTH+1:0] shifted;
    logic             q_bit;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] q_next;

    assign n_lane = n_reg[lane_reg];
    assign d_lane = d_reg[lane_reg];

    always_comb begin
        shifted = {p_reg, n_lane[bit_reg]};
        q_bit   = (shifted >= {2'b00, d_lane});
        p_next  = shifted[WIDTH:0];
        if (q_bit) begin
            p_next = shifted[WIDTH:0] - {1'b0, d_lane};
        end
        q_next  = {qacc_reg, q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            lane_reg      <= '0;
            bit_reg       <= '0;
            p_reg         <= '0;
            qacc_reg      <= '0;
            dz_reg        <= '0;
            for (int i = 0; i < 4; i++) begin
                n_reg[i] <= '0;
                d_reg[i] <= '0;
                q_reg[i] <= '0;
                r_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            n_reg[i] <= n_in[i];
                            d_reg[i] <= d_in[i];
                            q_reg[i] <= '0;
                            r_reg[i] <= '0;
                        end
                        dz_reg    <= '0;
                        lane_reg  <= '0;
                        bit_reg   <= BW'(WIDTH - 1);
                        p_reg     <= '0;
                        qacc_reg  <= '0;
                        state_reg <= DIV;
                    end
                end
                DIV: begin
                    p_reg    <= p_next;
                    qacc_reg <= q_next[WIDTH-2:0];
                    if (bit_reg == '0) begin
                        // Last bit of this lane: commit the result and move on.
                        q_reg[lane_reg]  <= q_next;
                        r_reg[lane_reg]  <= p_next[WIDTH-1:0];
                        dz_reg[lane_reg] <= (d_lane == '0);
                        p_reg            <= '0;
                        qacc_reg         <= '0;
                        bit_reg          <= BW'(WIDTH - 1);
                        lane_reg         <= lane_reg + 2'd1;
                        if (lane_reg == 2'd3) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end
                    end else begin
                        bit_reg <= bit_reg - BW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.q1 = q_reg[0];
    assign bus.q2 = q_reg[1];
    assign bus.q3 = q_reg[2];
    assign bus.q4 = q_reg[3];
    assign bus.r1 = r_reg[0];
    assign bus.r2 = r_reg[1];
    assign bus.r3 = r_reg[2];
    assign bus.r4 = r_reg[3];
    assign bus.dz = dz_reg;
endmodule
